// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared CHIP-8 memory: one transaction at a time,
// round-robin on contention, one-cycle ack pulse per completed request.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_ack,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_read_ack,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t                       r_state, w_state_next;
    logic                         r_last_grant, w_last_grant_next;
    logic                         r_grant, w_grant_next;
    logic                         r_we, w_we_next;
    logic                         r_mem_read, w_mem_read_next;
    logic                         r_mem_write, w_mem_write_next;
    logic [ADDR_WIDTH-1:0]        r_mem_read_addr, w_mem_read_addr_next;
    logic [ADDR_WIDTH-1:0]        r_mem_write_addr, w_mem_write_addr_next;
    logic [DATA_WIDTH-1:0]        r_mem_write_data, w_mem_write_data_next;
    logic [1:0]                   r_ack, w_ack_next;
    logic [1:0][DATA_WIDTH-1:0]   r_rdata, w_rdata_next;

    logic                         w_pick1;
    logic                         w_sel_we;
    logic [ADDR_WIDTH-1:0]        w_sel_addr;
    logic [DATA_WIDTH-1:0]        w_sel_wdata;

    // On a tie the port that did not win last time gets the grant.
    assign w_pick1     = p1_req & (~p0_req | ~r_last_grant);
    assign w_sel_we    = w_pick1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_pick1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_pick1 ? p1_wdata : p0_wdata;

    always_comb begin
        w_state_next          = r_state;
        w_last_grant_next     = r_last_grant;
        w_grant_next          = r_grant;
        w_we_next             = r_we;
        w_mem_read_next       = 1'b0;
        w_mem_write_next      = 1'b0;
        w_mem_read_addr_next  = r_mem_read_addr;
        w_mem_write_addr_next = r_mem_write_addr;
        w_mem_write_data_next = r_mem_write_data;
        w_ack_next            = 2'b00;
        w_rdata_next          = '0;
        case (r_state)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    w_grant_next      = w_pick1;
                    w_last_grant_next = w_pick1;
                    w_we_next         = w_sel_we;
                    w_state_next      = ST_ISSUE;
                    if (w_sel_we) begin
                        w_mem_write_next      = 1'b1;
                        w_mem_write_addr_next = w_sel_addr;
                        w_mem_write_data_next = w_sel_wdata;
                    end else begin
                        w_mem_read_next      = 1'b1;
                        w_mem_read_addr_next = w_sel_addr;
                    end
                end
            end
            ST_ISSUE: begin
                if (r_we) begin
                    w_ack_next[r_grant] = 1'b1;
                    w_state_next        = ST_DONE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_read_ack) begin
                    w_ack_next[r_grant]   = 1'b1;
                    w_rdata_next[r_grant] = mem_read_data;
                    w_state_next          = ST_DONE;
                end
            end
            // DONE never samples requests, so a still-high req waits for IDLE.
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= 1'b1;
            r_grant          <= 1'b0;
            r_we             <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_read_addr  <= '0;
            r_mem_write_addr <= '0;
            r_mem_write_data <= '0;
            r_ack            <= 2'b00;
            r_rdata          <= '0;
        end else begin
            r_state          <= w_state_next;
            r_last_grant     <= w_last_grant_next;
            r_grant          <= w_grant_next;
            r_we             <= w_we_next;
            r_mem_read       <= w_mem_read_next;
            r_mem_write      <= w_mem_write_next;
            r_mem_read_addr  <= w_mem_read_addr_next;
            r_mem_write_addr <= w_mem_write_addr_next;
            r_mem_write_data <= w_mem_write_data_next;
            r_ack            <= w_ack_next;
            r_rdata          <= w_rdata_next;
        end
    end

    assign p0_ack         = r_ack[0];
    assign p1_ack         = r_ack[1];
    assign p0_rdata       = r_rdata[0];
    assign p1_rdata       = r_rdata[1];
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_read_addr  = r_mem_read_addr;
    assign mem_write_addr = r_mem_write_addr;
    assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model plus a transaction-level reference
// (request queues, round-robin rule, shadow memory, fixed latency offsets).
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic          p0_ack, p1_ack;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [DW-1:0] mem_read_data, mem_write_data;
    logic          mem_read_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .mem_write(mem_write), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    function automatic logic [DW-1:0] init_byte(input logic [AW-1:0] a);
        if (a == 12'h200) return 8'hA2;
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3C;
    endfunction

    // Memory model: read data arrives 1 + ack_stall cycles after mem_read.
    logic [DW-1:0] mem_arr [0:4095];
    logic          mem_init_done = 1'b0;
    logic          pend = 1'b0;
    int            stall_cnt = 0;
    logic [DW-1:0] pend_data = '0;
    int            ack_stall = 0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= init_byte(12'(i));
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem_arr[mem_write_addr] <= mem_write_data;
        end
        mem_read_ack  <= 1'b0;
        mem_read_data <= 8'($urandom);
        if (mem_read) begin
            if (ack_stall == 0) begin
                mem_read_ack  <= 1'b1;
                mem_read_data <= mem_arr[mem_read_addr];
                pend          <= 1'b0;
            end else begin
                pend      <= 1'b1;
                stall_cnt <= ack_stall;
                pend_data <= mem_arr[mem_read_addr];
            end
        end else if (pend) begin
            if (stall_cnt <= 1) begin
                mem_read_ack  <= 1'b1;
                mem_read_data <= pend_data;
                pend          <= 1'b0;
            end else begin
                stall_cnt <= stall_cnt - 1;
            end
        end
    end

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] ref_mem [0:4095];
    bit            ref_last;
    txn_t          q0[$];
    txn_t          q1[$];
    bit            grant_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_p0_ack"}, p0_ack, 0);
        check({tag, "_p1_ack"}, p1_ack, 0);
        check({tag, "_p0_rdata"}, p0_rdata, 0);
        check({tag, "_p1_rdata"}, p1_rdata, 0);
        check({tag, "_rd_addr"}, mem_read_addr, 0);
        check({tag, "_wr_addr"}, mem_write_addr, 0);
        check({tag, "_wr_data"}, mem_write_data, 0);
    endtask

    task automatic drive_reqs();
        p0_req = (q0.size() > 0);
        p1_req = (q1.size() > 0);
        if (q0.size() > 0) begin p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata; end
        if (q1.size() > 0) begin p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata; end
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        drive_reqs();
        reset = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        ref_last = 1'b1;
    endtask

    // Runs both request queues to completion, checking every cycle against
    // the expected issue cycle (+1) and ack cycle (+2 write, +3+stall read).
    task automatic run_engine(input int budget);
        bit busy, cool, w;
        int k, ack_k, cyc;
        txn_t cur;
        logic [DW-1:0] exp_rd;
        busy = 0; cool = 0; w = 0; k = 0; ack_k = 0; cyc = 0; cur = '0;
        while ((busy || cool || q0.size() > 0 || q1.size() > 0) && cyc < budget) begin
            if (cool) begin
                cool = 0;
            end else if (!busy) begin
                drive_reqs();
                if (p0_req || p1_req) begin
                    w = (p0_req && p1_req) ? !ref_last : p1_req;
                    ref_last = w;
                    cur = w ? q1[0] : q0[0];
                    busy = 1; k = 0;
                    ack_k = cur.we ? 2 : 3 + ack_stall;
                end
            end
            tick(); cyc++;
            if (busy) k++;
            check("mem_read", mem_read, busy && k == 1 && !cur.we);
            check("mem_write", mem_write, busy && k == 1 && cur.we);
            if (busy && k == 1 && cur.we) begin
                check("mem_write_addr", mem_write_addr, cur.addr);
                check("mem_write_data", mem_write_data, cur.wdata);
            end
            if (busy && k == 1 && !cur.we) check("mem_read_addr", mem_read_addr, cur.addr);
            exp_rd = (busy && k == ack_k && !cur.we) ? ref_mem[cur.addr] : 8'h00;
            check("p0_ack", p0_ack, busy && !w && k == ack_k);
            check("p1_ack", p1_ack, busy && w && k == ack_k);
            check("p0_rdata", p0_rdata, (!w) ? exp_rd : 8'h00);
            check("p1_rdata", p1_rdata, w ? exp_rd : 8'h00);
            if (busy && k == ack_k) begin
                if (cur.we) ref_mem[cur.addr] = cur.wdata;
                grant_log.push_back(w);
                if (w) begin
                    void'(q1.pop_front());
                    if (q1.size() > 0) begin p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata; end
                end else begin
                    void'(q0.pop_front());
                    if (q0.size() > 0) begin p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata; end
                end
                busy = 0; cool = 1;
            end
        end
        if (cyc >= budget) begin
            n_cmp++; n_err++;
            $error("FAIL engine_timeout: observed %0d cycles, required completion within %0d", cyc, budget);
            q0.delete(); q1.delete();
        end
        drive_reqs();
    endtask

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        ref_last = 1'b1;
        do_reset();

        // Port 0 read only, memory holds 0xA2 at 0x200.
        grant_log.delete();
        q0.push_back(mk(1'b0, 12'h200, 8'h00));
        run_engine(50);
        check("t1_ngrants", grant_log.size(), 1);
        $display("txn: p0 read 0x200 done, grants=%0d", grant_log.size());

        // Port 1 write, then readback on port 0.
        q1.push_back(mk(1'b1, 12'h300, 8'h5C));
        run_engine(50);
        q0.push_back(mk(1'b0, 12'h300, 8'h00));
        run_engine(50);
        $display("txn: p1 write 0x300=5C, p0 readback");

        // First tie after reset goes to port 0.
        do_reset();
        grant_log.delete();
        q0.push_back(mk(1'b0, 12'h050, 8'h00));
        q1.push_back(mk(1'b0, 12'h055, 8'h00));
        run_engine(50);
        check("t3_ngrants", grant_log.size(), 2);
        for (int i = 0; i < grant_log.size() && i < 2; i++) check("t3_order", grant_log[i], i % 2);
        $display("txn: simultaneous reads 0x050/0x055 done");

        // Continuous contention, mixed reads and writes.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'($urandom), 12'(12'h400 + $urandom_range(0, 7)), 8'($urandom)));
            q1.push_back(mk(1'($urandom), 12'(12'h400 + $urandom_range(0, 7)), 8'($urandom)));
        end
        run_engine(100);
        check("t4_ngrants", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) check("t4_alternate", grant_log[i], i % 2);
        $display("txn: contention run of %0d grants", grant_log.size());

        // Held request: same read stays asserted across three passes.
        grant_log.delete();
        for (int i = 0; i < 3; i++) q0.push_back(mk(1'b0, 12'h123, 8'h00));
        run_engine(60);
        check("t5_ngrants", grant_log.size(), 3);
        $display("txn: held p0 read, %0d transactions", grant_log.size());

        // Randomized traffic with variable read latency.
        for (int it = 0; it < 30; it++) begin
            int n0, n1;
            ack_stall = $urandom_range(0, 2);
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++)
                q0.push_back(mk(1'($urandom), 12'(12'h600 + $urandom_range(0, 15)), 8'($urandom)));
            for (int i = 0; i < n1; i++)
                q1.push_back(mk(1'($urandom), 12'(12'h600 + $urandom_range(0, 15)), 8'($urandom)));
            run_engine(200);
            $display("txn: random batch %0d p0=%0d p1=%0d stall=%0d", it, n0, n1, ack_stall);
        end

        // Reset during WAIT of a port 0 read; the late memory ack must be ignored.
        ack_stall = 2;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h2AB; p0_wdata = 8'h00;
        tick();
        check("rst_mid_mem_read", mem_read, 1);
        tick();
        check("rst_mid_wait_ack", p0_ack, 0);
        reset = 1'b1;
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        p0_req = 1'b0;
        ref_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_late_p0_ack", p0_ack, 0);
            check("rst_late_p0_rdata", p0_rdata, 0);
        end
        ack_stall = 0;
        grant_log.delete();
        q0.push_back(mk(1'b0, 12'h2AB, 8'h00));
        run_engine(50);
        check("t6_ngrants", grant_log.size(), 1);
        $display("txn: reset mid-read, then normal p0 read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
